rf_arbiter: RTL and testbench

Arbitrates the shared register file between two requesters: port A, the SPI host interface (re/we/addr/data strobes), and port B, the internal waveform sequencer core. It serialises accesses and drives one set of register-file strobes. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the SPI interface, the core, and the register file, all on sys_clk_i.

---
 rtl/rf_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
// Two-port register-file arbiter: serialises SPI-host (A) and sequencer (B) accesses onto one strobe set.
// Define RF_ARB_RR_EN for round-robin collision handling; default is fixed priority with A winning.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 8
`endif
`ifndef RF_DATA_WIDTH
`define RF_DATA_WIDTH 16
`endif

module rf_arbiter #(
  parameter int ADDR_WIDTH = `RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = `RF_DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  a_re_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_ack_o,
  input  logic                  b_re_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_ack_o,
  output logic                  rf_re_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  // Requests are levels held until ack; a request with we high is a write even if re is also high.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  win_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            wait_cnt;
  logic                  a_req;
  logic                  b_req;
  logic                  grant_b;
  logic                  wait_done;

  assign a_req     = a_re_i | a_we_i;
  assign b_req     = b_re_i | b_we_i;
  assign wait_done = (wait_cnt == WAIT_LAST);

`ifdef RF_ARB_RR_EN
  // ptr_q names the port that wins the next collision; it always points away from the last grant.
  logic ptr_q;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      ptr_q <= 1'b0;
    end else if (state == IDLE && (a_req || b_req)) begin
      ptr_q <= ~grant_b;
    end
  end

  always_comb begin
    grant_b = 1'b0;
    if (a_req && b_req) grant_b = ptr_q;
    else if (b_req)     grant_b = 1'b1;
  end
`else
  always_comb begin
    grant_b = 1'b0;
    if (b_req && !a_req) grant_b = 1'b1;
  end
`endif

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req || b_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? ACK : WAIT;
      WAIT:    if (wait_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      a_rdata_o <= '0;
      b_rdata_o <= '0;
    end else begin
      if (state == IDLE && (a_req || b_req)) begin
        win_q   <= grant_b;
        we_q    <= grant_b ? b_we_i   : a_we_i;
        addr_q  <= grant_b ? b_addr_i : a_addr_i;
        wdata_q <= grant_b ? b_data_i : a_data_i;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      else               wait_cnt <= '0;
      if (state == WAIT && wait_done) begin
        if (win_q) b_rdata_o <= rf_rdata_i;
        else       a_rdata_o <= rf_rdata_i;
      end
    end
  end

  // Outputs decode the state register directly so reset clears them without waiting for a clock.
  always_comb begin
    rf_re_o    = 1'b0;
    rf_we_o    = 1'b0;
    rf_addr_o  = '0;
    rf_wdata_o = '0;
    a_ack_o    = 1'b0;
    b_ack_o    = 1'b0;
    busy_o     = (state != IDLE);
    state_o    = state;
    if (state == ISSUE) begin
      rf_re_o    = ~we_q;
      rf_we_o    = we_q;
      rf_addr_o  = addr_q;
      rf_wdata_o = wdata_q;
    end
    if (state == ACK) begin
      a_ack_o = ~win_q;
      b_ack_o = win_q;
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: transaction-level schedule model feeds expected queues, negedge monitor checks.
`timescale 1ns/1ps
module tb_rf_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RD_LAT = 2;
  localparam int CW = 20;
  localparam int RFW = 1 + AW + DW + CW;
  localparam int AKW = 1 + 1 + DW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_re = 0, a_we = 0, b_re = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic [DW-1:0] a_rdata, b_rdata, rf_wdata, rf_rdata;
  logic          a_ack, b_ack, rf_re, rf_we, busy;
  logic [AW-1:0] rf_addr;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  rf_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .a_re_i(a_re), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_rdata_o(a_rdata), .a_ack_o(a_ack),
    .b_re_i(b_re), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_rdata_o(b_rdata), .b_ack_o(b_ack),
    .rf_re_o(rf_re), .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_wdata_o(rf_wdata),
    .rf_rdata_i(rf_rdata), .busy_o(busy), .state_o(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: writes on strobe, read data appears RD_LAT cycles after the strobe, junk otherwise.
  logic [DW-1:0] rf_mem [256];
  logic [DW-1:0] pipe [RD_LAT];
  initial begin
    for (int i = 0; i < 256; i++) rf_mem[i] = '0;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  end
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    pipe[0] <= rf_re ? rf_mem[rf_addr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rf_rdata = pipe[RD_LAT-1];

  // Reference: one access at a time, strobe at +1, ack at +2 (+RD_LAT for reads), idle again after ack.
  logic [DW-1:0]  m_mem [256];
  logic [RFW-1:0] exp_rf_q [$];
  logic [AKW-1:0] exp_ack_q [$];
  int             free_cyc = 0, busy_lo = 1, busy_hi = 0, m_lat;
  logic           m_ptr = 1'b0, m_win, m_we;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data, m_rd;
  initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      exp_rf_q.delete();
      exp_ack_q.delete();
      free_cyc = cyc + 1;
      busy_lo = 1;
      busy_hi = 0;
      m_ptr = 1'b0;
    end else if (cyc >= free_cyc && (a_re || a_we || b_re || b_we)) begin
      if (!(a_re || a_we)) m_win = 1'b1;
      else if (!(b_re || b_we)) m_win = 1'b0;
      else begin
`ifdef RF_ARB_RR_EN
        m_win = m_ptr;
`else
        m_win = 1'b0;
`endif
      end
      m_ptr  = ~m_win;
      m_we   = m_win ? b_we : a_we;
      m_addr = m_win ? b_addr : a_addr;
      m_data = m_win ? b_data : a_data;
      m_lat  = m_we ? 2 : 2 + RD_LAT;
      if (m_we) m_mem[m_addr] = m_data;
      m_rd = m_we ? '0 : m_mem[m_addr];
      exp_rf_q.push_back({m_we, m_addr, m_data, CW'(cyc + 1)});
      exp_ack_q.push_back({m_win, ~m_we, m_rd, CW'(cyc + m_lat)});
      busy_lo  = cyc + 1;
      busy_hi  = cyc + m_lat;
      free_cyc = cyc + m_lat + 1;
    end
  end

  // Monitor
  logic [DW-1:0]  exp_rd_a = '0, exp_rd_b = '0;
  logic [RFW-1:0] e_rf;
  logic [AKW-1:0] e_ak;
  logic           exp_busy;
  logic [DW-1:0]  got_rd;

  always @(negedge clk) begin
    if (rst) begin
      exp_rd_a = '0;
      exp_rd_b = '0;
      total++;
      if (rf_re || rf_we || rf_addr != '0 || rf_wdata != '0 || a_ack || b_ack || busy ||
          a_rdata != '0 || b_rdata != '0) begin
        bad++;
        $display("FAIL reset_outputs: re=%b we=%b addr=%h wd=%h acks=%b%b busy=%b rd=%h/%h required all 0",
                 rf_re, rf_we, rf_addr, rf_wdata, a_ack, b_ack, busy, a_rdata, b_rdata);
      end
    end else begin
      if (rf_re || rf_we) begin
        total++;
        if (exp_rf_q.size() == 0) begin
          bad++;
          $display("FAIL rf_strobe: unexpected strobe re=%b we=%b addr=%h at cycle %0d", rf_re, rf_we, rf_addr, cyc);
        end else begin
          e_rf = exp_rf_q.pop_front();
          if ((rf_re && rf_we) || {rf_we, rf_addr, rf_wdata, CW'(cyc)} != e_rf) begin
            bad++;
            $display("FAIL rf_strobe: got re=%b we=%b addr=%h wd=%h cyc=%0d required we=%b addr=%h wd=%h cyc=%0d",
                     rf_re, rf_we, rf_addr, rf_wdata, cyc, e_rf[RFW-1], e_rf[CW+DW +: AW],
                     e_rf[CW +: DW], e_rf[CW-1:0]);
          end
        end
      end else if (rf_addr != '0 || rf_wdata != '0) begin
        total++;
        bad++;
        $display("FAIL rf_idle_bus: addr=%h wdata=%h required 0 outside issue", rf_addr, rf_wdata);
      end
      if (a_ack || b_ack) begin
        total++;
        if (exp_ack_q.size() == 0 || (a_ack && b_ack)) begin
          bad++;
          $display("FAIL ack: unexpected a_ack=%b b_ack=%b at cycle %0d", a_ack, b_ack, cyc);
          if (exp_ack_q.size() != 0) void'(exp_ack_q.pop_front());
        end else begin
          e_ak   = exp_ack_q.pop_front();
          got_rd = b_ack ? b_rdata : a_rdata;
          if (b_ack != e_ak[AKW-1] || CW'(cyc) != e_ak[CW-1:0] ||
              (e_ak[AKW-2] && got_rd != e_ak[CW +: DW])) begin
            bad++;
            $display("FAIL ack: got port=%0d rdata=%h cyc=%0d required port=%0d read=%b rdata=%h cyc=%0d",
                     b_ack, got_rd, cyc, e_ak[AKW-1], e_ak[AKW-2], e_ak[CW +: DW], e_ak[CW-1:0]);
          end
          if (e_ak[AKW-2]) begin
            if (e_ak[AKW-1]) exp_rd_b = e_ak[CW +: DW];
            else             exp_rd_a = e_ak[CW +: DW];
          end
        end
      end
      exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
      total++;
      if (busy != exp_busy || a_rdata != exp_rd_a || b_rdata != exp_rd_b) begin
        bad++;
        $display("FAIL hold: busy=%b a_rdata=%h b_rdata=%h required busy=%b a_rdata=%h b_rdata=%h cyc=%0d",
                 busy, a_rdata, b_rdata, exp_busy, exp_rd_a, exp_rd_b, cyc);
      end
    end
  end

  // Drivers
  task automatic set_port(input int p, input logic re, input logic we,
                          input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (p == 0) begin a_re = re; a_we = we; a_addr = ad; a_data = d; end
    else        begin b_re = re; b_we = we; b_addr = ad; b_data = d; end
  endtask

  task automatic drive(input int p, input logic re, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input int gap, input bit wig);
    int  n = 0;
    bit  acked = 0;
    repeat (gap) begin @(posedge clk); #1; end
    set_port(p, re, we, ad, d);
    while (!acked && n < 300) begin
      @(negedge clk);
      if ((p == 0) ? a_ack : b_ack) acked = 1;
      else begin
        n++;
        if (wig && n == 3) set_port(p, re, we, AW'($urandom_range(0, 15)), DW'($urandom));
      end
    end
    if (!acked) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: port %0d got no ack within 300 cycles", p);
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic run_port(input int p, input int cnt);
    int sel;
    for (int i = 0; i < cnt; i++) begin
      sel = $urandom_range(0, 3);
      drive(p, sel != 1, sel == 1 || sel == 2, AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 8'h05, 16'h1234, 0, 0);
    drive(0, 1'b0, 1'b1, 8'h03, 16'hBEEF, 1, 0);
    drive(1, 1'b1, 1'b0, 8'h03, 16'h0000, 1, 0);
    fork
      begin
        drive(0, 1'b0, 1'b1, 8'h10, 16'h1111, 0, 0);
        drive(0, 1'b0, 1'b1, 8'h11, 16'h2222, 0, 0);
        drive(0, 1'b0, 1'b1, 8'h12, 16'h3333, 0, 0);
      end
      drive(1, 1'b0, 1'b1, 8'h13, 16'h4444, 0, 0);
    join
    drive(0, 1'b1, 1'b1, 8'h07, 16'h7777, 1, 0);
    fork
      drive(1, 1'b1, 1'b0, 8'h05, 16'h0000, 1, 0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!rf_re && n < 50);
        if (!rf_re) begin
          total++;
          bad++;
          $display("FAIL reset_wait: no read strobe within 50 cycles");
        end
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
      end
    join
    drive(0, 1'b1, 1'b0, 8'h03, 16'h0000, 1, 1);
    drive(0, 1'b1, 1'b0, 8'h03, 16'h0000, 0, 0);
    fork
      run_port(0, 40);
      run_port(1, 40);
    join
    repeat (20) @(posedge clk);
    total++;
    if (exp_rf_q.size() != 0 || exp_ack_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d strobes and %0d acks outstanding, required 0", exp_rf_q.size(), exp_ack_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
